// File: rtl/reg_bank_ctx.sv
// General-purpose register bank with write-through read ports and a
// whole-bank context stack for interrupt/call entry and exit.

module reg_bank_ctx_chk #(
  parameter int CTX_DEPTH = 4,
  parameter int SW        = 3
) (
  input logic          clk,
  input logic          rst,
  input logic [SW-1:0] ctxCount,
  input logic          ctxFull,
  input logic          ctxEmpty
);

  countInRange: assert property (@(posedge clk) disable iff (rst)
    ctxCount <= SW'(CTX_DEPTH));

  fullDecode: assert property (@(posedge clk) disable iff (rst)
    ctxFull == (ctxCount == SW'(CTX_DEPTH)));

  flagsExclusive: assert property (@(posedge clk) disable iff (rst)
    !(ctxFull && ctxEmpty));

endmodule

module reg_bank_ctx #(
  parameter  int WIDTH     = 16,
  parameter  int NREGS     = 4,
  parameter  int CTX_DEPTH = 4,
  localparam int AW        = $clog2(NREGS),
  localparam int SW        = $clog2(CTX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             push,
  input  logic             pop,
  input  logic             err_clr,
  output logic [SW-1:0]    ctx_count,
  output logic             ctx_full,
  output logic             ctx_empty,
  output logic             ctx_err
);

  localparam int SPW = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;

  logic [WIDTH-1:0] bankR     [NREGS];
  logic [WIDTH-1:0] bankNextS [NREGS];
  logic [WIDTH-1:0] stackR    [CTX_DEPTH][NREGS];
  logic [SW-1:0]    countR;
  logic [SW-1:0]    countNextS;
  logic [SPW-1:0]   pushIdxS;
  logic [SPW-1:0]   popIdxS;
  logic             errR;
  logic             pushOkS;
  logic             popOkS;
  logic             errSetS;
  logic [WIDTH-1:0] rdataAR;
  logic [WIDTH-1:0] rdataBR;

  assign ctx_full  = (countR == SW'(CTX_DEPTH));
  assign ctx_empty = (countR == {SW{1'b0}});
  assign ctx_count = countR;
  assign ctx_err   = errR;
  assign rdata_a   = rdataAR;
  assign rdata_b   = rdataBR;

  // Top of stack is one below the count; the next free slot is the count itself.
  assign pushIdxS = SPW'(countR);
  assign popIdxS  = SPW'(countR - SW'(1'b1));

  // Classify the stack request: legal push, legal pop, or an error case.
  always_comb begin
    pushOkS    = 1'b0;
    popOkS     = 1'b0;
    errSetS    = 1'b0;
    countNextS = countR;
    case ({push, pop})
      2'b10: begin
        if (ctx_full) begin
          errSetS = 1'b1;
        end else begin
          pushOkS    = 1'b1;
          countNextS = countR + SW'(1'b1);
        end
      end
      2'b01: begin
        if (ctx_empty) begin
          errSetS = 1'b1;
        end else begin
          popOkS     = 1'b1;
          countNextS = countR - SW'(1'b1);
        end
      end
      2'b11:   errSetS    = 1'b1;
      default: countNextS = countR;
    endcase
  end

  // Next bank image: a write overrides a restore, which overrides the held value.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      if (we && (waddr == AW'(i))) begin
        bankNextS[i] = wdata;
      end else if (popOkS) begin
        bankNextS[i] = stackR[popIdxS][i];
      end else begin
        bankNextS[i] = bankR[i];
      end
    end
  end

  // Live bank, stack pointer, sticky error and read ports.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        bankR[i] <= {WIDTH{1'b0}};
      end
      countR  <= {SW{1'b0}};
      errR    <= 1'b0;
      rdataAR <= {WIDTH{1'b0}};
      rdataBR <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        bankR[i] <= bankNextS[i];
      end
      countR <= countNextS;
      if (errSetS) begin
        errR <= 1'b1;
      end else if (err_clr) begin
        errR <= 1'b0;
      end
      rdataAR <= bankNextS[raddr_a];
      rdataBR <= bankNextS[raddr_b];
    end
  end

  // Snapshot storage holds pre-write bank values; contents need no reset.
  always_ff @(posedge clk) begin
    if (pushOkS && !rst) begin
      for (int i = 0; i < NREGS; i++) begin
        stackR[pushIdxS][i] <= bankR[i];
      end
    end
  end

  reg_bank_ctx_chk #(
    .CTX_DEPTH(CTX_DEPTH),
    .SW       (SW)
  ) uChk (
    .clk     (clk),
    .rst     (rst),
    .ctxCount(countR),
    .ctxFull (ctx_full),
    .ctxEmpty(ctx_empty)
  );

endmodule

// File: tb/tb_reg_bank_ctx.sv
// Bench for reg_bank_ctx: directed scenarios plus random traffic, compared
// every cycle against a queue-based model of the bank and context stack.

module tb_reg_bank_ctx;

  localparam int WIDTH     = 16;
  localparam int NREGS     = 4;
  localparam int CTX_DEPTH = 4;
  localparam int AW        = 2;
  localparam int SW        = 3;

  typedef logic [NREGS-1:0][WIDTH-1:0] bank_t;

  logic             clk;
  logic             rst;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] rdata_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_b;
  logic             push;
  logic             pop;
  logic             err_clr;
  logic [SW-1:0]    ctx_count;
  logic             ctx_full;
  logic             ctx_empty;
  logic             ctx_err;

  reg_bank_ctx #(.WIDTH(WIDTH), .NREGS(NREGS), .CTX_DEPTH(CTX_DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .raddr_a  (raddr_a),
    .rdata_a  (rdata_a),
    .raddr_b  (raddr_b),
    .rdata_b  (rdata_b),
    .push     (push),
    .pop      (pop),
    .err_clr  (err_clr),
    .ctx_count(ctx_count),
    .ctx_full (ctx_full),
    .ctx_empty(ctx_empty),
    .ctx_err  (ctx_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bank_t            mBank;
  bank_t            stk[$];
  logic             mErr;
  logic [WIDTH-1:0] expRa;
  logic [WIDTH-1:0] expRb;
  int               nChecks = 0;
  int               nFails  = 0;
  bit               checkEn = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    mBank = '0;
    stk.delete();
    mErr  = 1'b0;
    expRa = '0;
    expRb = '0;
  endtask

  // One clock of the architectural rules, evaluated on the inputs present at the edge.
  task automatic modelStep();
    int    sz;
    bit    doPush, doPop, errSet;
    bank_t nb;
    if (rst) begin
      resetModel();
    end else begin
      sz     = stk.size();
      doPush = push && !pop && (sz < CTX_DEPTH);
      doPop  = pop && !push && (sz > 0);
      errSet = (push && pop) || (push && !pop && sz == CTX_DEPTH) || (pop && !push && sz == 0);
      nb = mBank;
      if (doPush) stk.push_back(mBank);
      if (doPop) nb = stk.pop_back();
      if (we) nb[waddr] = wdata;
      mBank = nb;
      if (errSet) mErr = 1'b1;
      else if (err_clr) mErr = 1'b0;
      expRa = mBank[raddr_a];
      expRb = mBank[raddr_b];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic setIdle();
    we      = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    err_clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      chk("cmp_rdata_a",   rdata_a,   expRa);
      chk("cmp_rdata_b",   rdata_b,   expRb);
      chk("cmp_ctx_count", ctx_count, 32'(stk.size()));
      chk("cmp_ctx_full",  ctx_full,  (stk.size() == CTX_DEPTH));
      chk("cmp_ctx_empty", ctx_empty, (stk.size() == 0));
      chk("cmp_ctx_err",   ctx_err,   mErr);
    end
  end

  initial begin
    int r;
    rst = 1'b1;
    setIdle();
    waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;
    resetModel();
    tick();
    tick();
    rst = 1'b0;
    checkEn = 1'b1;
    chk("reset_rdata_a", rdata_a, 16'h0000);
    chk("reset_count",   ctx_count, 3'd0);
    chk("reset_empty",   ctx_empty, 1'b1);

    // Mid-cycle asynchronous reset clears outputs before the next edge.
    we = 1'b1; waddr = 2'd1; wdata = 16'h7777; raddr_a = 2'd1;
    tick();
    we = 1'b0;
    chk("pre_rst_rdata_a", rdata_a, 16'h7777);
    push = 1'b1;
    tick();
    push = 1'b0;
    rst = 1'b1;
    resetModel();
    #1;
    chk("midrst_rdata_a", rdata_a,   16'h0000);
    chk("midrst_rdata_b", rdata_b,   16'h0000);
    chk("midrst_count",   ctx_count, 3'd0);
    chk("midrst_err",     ctx_err,   1'b0);
    tick();
    rst = 1'b0;

    // Hold.
    we = 1'b1; waddr = 2'd2; wdata = 16'h1234; raddr_a = 2'd2;
    tick();
    we = 1'b0;
    repeat (10) begin
      tick();
      chk("hold_rdata_a", rdata_a, 16'h1234);
    end

    // Write-through bypass.
    we = 1'b1; waddr = 2'd0; wdata = 16'h5A5A;
    tick();
    waddr = 2'd1; wdata = 16'hBEEF; raddr_a = 2'd1; raddr_b = 2'd0;
    tick();
    we = 1'b0;
    chk("bypass_a", rdata_a, 16'hBEEF);
    chk("bypass_b", rdata_b, 16'h5A5A);

    // Push/pop round trip.
    for (int i = 0; i < NREGS; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = 16'(i + 1);
      tick();
    end
    we = 1'b0;
    push = 1'b1;
    tick();
    push = 1'b0;
    chk("rt_push_count", ctx_count, 3'd1);
    for (int i = 0; i < NREGS; i++) begin
      we = 1'b1; waddr = AW'(i); wdata = 16'hFFFF;
      tick();
    end
    we = 1'b0;
    pop = 1'b1; raddr_a = 2'd0; raddr_b = 2'd1;
    tick();
    pop = 1'b0;
    chk("rt_pop_count", ctx_count, 3'd0);
    chk("rt_r0", rdata_a, 16'h0001);
    chk("rt_r1", rdata_b, 16'h0002);
    raddr_a = 2'd2; raddr_b = 2'd3;
    tick();
    chk("rt_r2",  rdata_a, 16'h0003);
    chk("rt_r3",  rdata_b, 16'h0004);
    chk("rt_err", ctx_err, 1'b0);

    // Pop with coincident write.
    push = 1'b1;
    tick();
    push = 1'b0;
    pop = 1'b1; we = 1'b1; waddr = 2'd3; wdata = 16'hAAAA;
    tick();
    setIdle();
    chk("popw_r2", rdata_a, 16'h0003);
    chk("popw_r3", rdata_b, 16'hAAAA);
    raddr_a = 2'd0; raddr_b = 2'd1;
    tick();
    chk("popw_r0", rdata_a, 16'h0001);
    chk("popw_r1", rdata_b, 16'h0002);

    // Overflow: each push also rewrites reg0, so snapshots are distinguishable.
    for (int k = 1; k <= CTX_DEPTH + 1; k++) begin
      push = 1'b1; we = 1'b1; waddr = 2'd0; wdata = 16'h0100 + 16'(k);
      tick();
    end
    setIdle();
    chk("ovf_count", ctx_count, 3'd4);
    chk("ovf_full",  ctx_full,  1'b1);
    chk("ovf_err",   ctx_err,   1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("errclr_err", ctx_err, 1'b0);

    // Underflow.
    raddr_a = 2'd0; raddr_b = 2'd1;
    pop = 1'b1;
    tick();
    chk("pop_top_r0", rdata_a, 16'h0103);
    repeat (4) tick();
    pop = 1'b0;
    chk("unf_empty", ctx_empty, 1'b1);
    chk("unf_err",   ctx_err,   1'b1);
    chk("unf_r0",    rdata_a,   16'h0001);
    chk("unf_r1",    rdata_b,   16'h0002);

    // Collision: error set wins over clear.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    push = 1'b1;
    tick();
    tick();
    pop = 1'b1; err_clr = 1'b1;
    tick();
    setIdle();
    chk("coll_count", ctx_count, 3'd2);
    chk("coll_err",   ctx_err,   1'b1);
    chk("coll_r0",    rdata_a,   16'h0001);

    // Random traffic.
    repeat (3000) begin
      if ($urandom_range(0, 199) == 0) begin
        setIdle();
        rst = 1'b1;
        resetModel();
        tick();
        rst = 1'b0;
      end
      r       = $urandom_range(0, 7);
      push    = (r == 1) || (r == 3) || (r == 5);
      pop     = (r == 2) || (r == 3) || (r == 6);
      we      = ($urandom_range(0, 1) == 1);
      waddr   = AW'($urandom_range(0, NREGS - 1));
      wdata   = 16'($urandom);
      raddr_a = AW'($urandom_range(0, NREGS - 1));
      raddr_b = AW'($urandom_range(0, NREGS - 1));
      err_clr = ($urandom_range(0, 3) == 0);
      tick();
    end
    setIdle();
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
